// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the two-port SRAM arbiter: FSM state encoding and port indices.
package sram_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner select: a held lock beats everything, then round-robin or fixed priority.
module sram_arb_pick
    import sram_arbiter_pkg::*;
#(
    parameter bit RR = 1'b1
) (
    input  logic p0_valid,
    input  logic p1_valid,
    input  logic last,
    input  logic lock,
    input  logic lock_port,
    output logic any,
    output logic winner
);

    logic lock_valid;

    assign lock_valid = (lock_port == PORT1) ? p1_valid : p0_valid;

    always_comb begin
        any    = p0_valid | p1_valid;
        winner = PORT0;
        if (lock && lock_valid) begin
            winner = lock_port;
        end else if (p0_valid && p1_valid) begin
            winner = RR ? ~last : PORT0;
        end else if (p1_valid) begin
            winner = PORT1;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port (instruction / data) arbiter in front of a single SRAM frontend, with per-port lock
// for read-modify-write sequences.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter bit RR = 1'b1,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_valid,
    input  logic          p0_rw,
    input  logic [AW-1:0] p0_addr,
    input  logic [AW-1:0] p0_dtw,
    input  logic          p0_lock,
    output logic          p0_ready,
    output logic [AW-1:0] p0_dtr,
    input  logic          p1_valid,
    input  logic          p1_rw,
    input  logic [AW-1:0] p1_addr,
    input  logic [AW-1:0] p1_dtw,
    input  logic          p1_lock,
    output logic          p1_ready,
    output logic [AW-1:0] p1_dtr,
    output logic          mem_valid,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] mem_dtw,
    input  logic          mem_ready,
    input  logic [AW-1:0] mem_dtr,
    output logic          gnt,
    output logic          busy
);

    state_t        state_reg;
    logic          gnt_reg;
    logic          last_reg;
    logic          lock_reg;
    logic          lock_port_reg;
    logic          mem_rw_reg;
    logic [AW-1:0] mem_addr_reg;
    logic [AW-1:0] mem_dtw_reg;
    logic          any_valid;
    logic          winner;

    sram_arb_pick #(.RR(RR)) u_pick (
        .p0_valid  (p0_valid),
        .p1_valid  (p1_valid),
        .last      (last_reg),
        .lock      (lock_reg),
        .lock_port (lock_port_reg),
        .any       (any_valid),
        .winner    (winner)
    );

    // last_reg resets to port 1 so that the first tie after reset goes to port 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            gnt_reg       <= PORT0;
            last_reg      <= PORT1;
            lock_reg      <= 1'b0;
            lock_port_reg <= PORT0;
            mem_rw_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_dtw_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_valid) begin
                        state_reg    <= BUSY;
                        gnt_reg      <= winner;
                        last_reg     <= winner;
                        mem_rw_reg   <= (winner == PORT1) ? p1_rw   : p0_rw;
                        mem_addr_reg <= (winner == PORT1) ? p1_addr : p0_addr;
                        mem_dtw_reg  <= (winner == PORT1) ? p1_dtw  : p0_dtw;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        state_reg     <= IDLE;
                        lock_reg      <= (gnt_reg == PORT1) ? p1_lock : p0_lock;
                        lock_port_reg <= gnt_reg;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Valid drops in the ready cycle so the frontend never sees a stale request.
    assign busy      = (state_reg == BUSY);
    assign mem_valid = busy & ~mem_ready;
    assign p0_ready  = busy & mem_ready & (gnt_reg == PORT0);
    assign p1_ready  = busy & mem_ready & (gnt_reg == PORT1);
    assign p0_dtr    = mem_dtr;
    assign p1_dtr    = mem_dtr;
    assign mem_rw    = mem_rw_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_dtw   = mem_dtw_reg;
    assign gnt       = gnt_reg;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a round-robin and a fixed-priority instance share all inputs and are
// checked side by side with directed vectors, corner sequences and a randomized model run.
module tb_sram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        p0_valid, p0_rw, p0_lock, p1_valid, p1_rw, p1_lock;
    logic [31:0] p0_addr, p0_dtw, p1_addr, p1_dtw;
    logic        mem_ready;
    logic [31:0] mem_dtr;

    logic        r_p0_ready, r_p1_ready, r_mem_valid, r_mem_rw, r_gnt, r_busy;
    logic [31:0] r_p0_dtr, r_p1_dtr, r_mem_addr, r_mem_dtw;
    logic        f_p0_ready, f_p1_ready, f_mem_valid, f_mem_rw, f_gnt, f_busy;
    logic [31:0] f_p0_dtr, f_p1_dtr, f_mem_addr, f_mem_dtw;

    sram_arbiter #(.RR(1'b1), .AW(32)) dut_rr (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_dtw(p0_dtw), .p0_lock(p0_lock),
        .p0_ready(r_p0_ready), .p0_dtr(r_p0_dtr),
        .p1_valid(p1_valid), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_dtw(p1_dtw), .p1_lock(p1_lock),
        .p1_ready(r_p1_ready), .p1_dtr(r_p1_dtr),
        .mem_valid(r_mem_valid), .mem_rw(r_mem_rw), .mem_addr(r_mem_addr), .mem_dtw(r_mem_dtw),
        .mem_ready(mem_ready), .mem_dtr(mem_dtr), .gnt(r_gnt), .busy(r_busy)
    );

    sram_arbiter #(.RR(1'b0), .AW(32)) dut_fp (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_dtw(p0_dtw), .p0_lock(p0_lock),
        .p0_ready(f_p0_ready), .p0_dtr(f_p0_dtr),
        .p1_valid(p1_valid), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_dtw(p1_dtw), .p1_lock(p1_lock),
        .p1_ready(f_p1_ready), .p1_dtr(f_p1_dtr),
        .mem_valid(f_mem_valid), .mem_rw(f_mem_rw), .mem_addr(f_mem_addr), .mem_dtw(f_mem_dtw),
        .mem_ready(mem_ready), .mem_dtr(mem_dtr), .gnt(f_gnt), .busy(f_busy)
    );

    // One transaction: requests, locks, addresses, read data, cycles of mem_valid before
    // mem_ready, and the expected winner for the round-robin and fixed-priority instances.
    typedef struct {
        bit          v0, v1, rw0, rw1, l0, l1;
        logic [31:0] a0, a1, d;
        int          lat;
        bit          err, efp;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;
    int txn_no = 0;

    // Reference state per instance (0 = round-robin, 1 = fixed priority).
    bit m_last[2];
    bit m_lock[2];
    bit m_lport[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'b0, act}, {31'b0, exp});
    endtask

    // Spec rules: a port that completed with lock and is asking again wins; otherwise a tie goes
    // to the port not served last (RR) or to port 0 (fixed); a lone requester always wins.
    function automatic bit model_pick(input int inst, input bit v0, input bit v1);
        bit asking[2];
        asking[0] = v0;
        asking[1] = v1;
        if (m_lock[inst] && asking[m_lport[inst]]) return m_lport[inst];
        if (v0 && v1) return (inst == 0) ? !m_last[inst] : 1'b0;
        return v1;
    endfunction

    // Entry and exit: 1 time unit after a rising edge with both DUTs in IDLE.
    task automatic do_txn(input vec_t r, input bit drop);
        logic [31:0] ea_r, ea_f, ed_r, ed_f;
        logic        ew_r, ew_f;
        ea_r = r.err ? r.a1 : r.a0;
        ea_f = r.efp ? r.a1 : r.a0;
        ed_r = r.err ? ~r.a1 : ~r.a0;
        ed_f = r.efp ? ~r.a1 : ~r.a0;
        ew_r = r.err ? r.rw1 : r.rw0;
        ew_f = r.efp ? r.rw1 : r.rw0;
        p0_valid = r.v0; p0_rw = r.rw0; p0_addr = r.a0; p0_dtw = ~r.a0; p0_lock = r.l0;
        p1_valid = r.v1; p1_rw = r.rw1; p1_addr = r.a1; p1_dtw = ~r.a1; p1_lock = r.l1;
        mem_ready = 1'b0;
        mem_dtr = 32'h0;
        @(negedge clk);
        chk1("mem_valid_before_grant", r_mem_valid, 1'b0);
        @(negedge clk);
        chk1("mem_valid_rise", r_mem_valid, 1'b1);
        chk1("busy_rr", r_busy, 1'b1);
        chk1("busy_fp", f_busy, 1'b1);
        chk1("gnt_rr", r_gnt, r.err);
        chk1("gnt_fp", f_gnt, r.efp);
        chk("mem_addr_rr", r_mem_addr, ea_r);
        chk("mem_addr_fp", f_mem_addr, ea_f);
        chk("mem_dtw_rr", r_mem_dtw, ed_r);
        chk("mem_dtw_fp", f_mem_dtw, ed_f);
        chk1("mem_rw_rr", r_mem_rw, ew_r);
        chk1("mem_rw_fp", f_mem_rw, ew_f);
        // Upstream changes during BUSY must not reach the frontend.
        p0_addr = 32'hFFFF_FFFF; p1_addr = 32'hFFFF_FFFF;
        p0_dtw = 32'h0; p1_dtw = 32'h0;
        p0_rw = ~r.rw0; p1_rw = ~r.rw1;
        if (drop) begin
            p0_valid = 1'b0;
            p1_valid = 1'b0;
        end
        repeat (r.lat - 1) begin
            @(negedge clk);
            chk("mem_addr_hold_rr", r_mem_addr, ea_r);
            chk("mem_addr_hold_fp", f_mem_addr, ea_f);
            chk("mem_dtw_hold_rr", r_mem_dtw, ed_r);
            chk1("mem_rw_hold_rr", r_mem_rw, ew_r);
            chk1("mem_valid_hold", r_mem_valid, 1'b1);
            chk("ready_early_rr", {30'b0, r_p1_ready, r_p0_ready}, 32'd0);
        end
        @(posedge clk); #1;
        mem_ready = 1'b1;
        mem_dtr = r.d;
        @(negedge clk);
        chk1("mem_valid_ready_cycle_rr", r_mem_valid, 1'b0);
        chk1("mem_valid_ready_cycle_fp", f_mem_valid, 1'b0);
        chk("ready_rr", {30'b0, r_p1_ready, r_p0_ready}, r.err ? 32'd2 : 32'd1);
        chk("ready_fp", {30'b0, f_p1_ready, f_p0_ready}, r.efp ? 32'd2 : 32'd1);
        chk("p0_dtr_rr", r_p0_dtr, r.d);
        chk("p1_dtr_rr", r_p1_dtr, r.d);
        chk("p0_dtr_fp", f_p0_dtr, r.d);
        chk("p1_dtr_fp", f_p1_dtr, r.d);
        chk("mem_addr_ready_cycle_rr", r_mem_addr, ea_r);
        $display("txn %0d: rr gnt %0d fp gnt %0d rr addr %h dtr %h", txn_no, r_gnt, f_gnt,
                 r_mem_addr, r.d);
        txn_no++;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        @(negedge clk);
        chk1("busy_after_rr", r_busy, 1'b0);
        chk1("busy_after_fp", f_busy, 1'b0);
        chk("ready_after", {30'b0, r_p1_ready, r_p0_ready, f_p1_ready, f_p0_ready}, 32'd0);
        @(posedge clk); #1;
    endtask

    vec_t tbl[17];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        vec_t v;
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000, 32'h0,    32'hDEADBEEF, 4, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    32'h2000, 32'h11111111, 1, 1'b1, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1100, 32'h2100, 32'h22222222, 2, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1200, 32'h2200, 32'h33333333, 1, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1300, 32'h2300, 32'h44444444, 3, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1400, 32'h2400, 32'h55555555, 2, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    32'h2500, 32'h66666666, 2, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1600, 32'h0,    32'h77777777, 1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1700, 32'h2700, 32'h88888888, 1, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1800, 32'h2800, 32'h99999999, 2, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1900, 32'h2900, 32'hAAAAAAAA, 1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1A00, 32'h2A00, 32'hBBBBBBBB, 1, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,    32'h20,   32'hCCCCCCCC, 2, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1C00, 32'h20,   32'hDDDDDDDD, 1, 1'b1, 1'b1};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1D00, 32'h2D00, 32'hEEEEEEEE, 1, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,    32'h2E00, 32'h12345678, 1, 1'b1, 1'b1};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1F00, 32'h0,    32'h87654321, 1, 1'b0, 1'b0};

        reset = 1'b0;
        p0_valid = 1'b0; p0_rw = 1'b0; p0_addr = 32'h0; p0_dtw = 32'h0; p0_lock = 1'b0;
        p1_valid = 1'b0; p1_rw = 1'b0; p1_addr = 32'h0; p1_dtw = 32'h0; p1_lock = 1'b0;
        mem_ready = 1'b0;
        mem_dtr = 32'h0;

        // Reset state.
        #3;
        chk1("rst_mem_valid", r_mem_valid, 1'b0);
        chk1("rst_busy", r_busy, 1'b0);
        chk("rst_ready", {30'b0, r_p1_ready, r_p0_ready}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk1("rst_gnt", r_gnt, 1'b0);
        chk("rst_mem_addr", r_mem_addr, 32'h0);
        chk("rst_mem_dtw", r_mem_dtw, 32'h0);
        chk1("rst_mem_rw", r_mem_rw, 1'b0);
        chk1("idle_mem_valid", r_mem_valid, 1'b0);
        @(posedge clk); #1;

        foreach (tbl[i]) do_txn(tbl[i], 1'b0);

        // mem_ready while idle raises no ready.
        mem_ready = 1'b1;
        mem_dtr = 32'h5A5A5A5A;
        @(negedge clk);
        chk("idle_mem_ready_rr", {30'b0, r_p1_ready, r_p0_ready}, 32'd0);
        chk("idle_mem_ready_fp", {30'b0, f_p1_ready, f_p0_ready}, 32'd0);
        chk1("idle_mem_ready_busy", r_busy, 1'b0);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk1("idle_stays_idle", r_busy, 1'b0);
        @(posedge clk); #1;

        // Requester drops valid mid-BUSY: transaction still completes.
        v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h3000, 32'h0, 32'hCAFEF00D, 3, 1'b0, 1'b0};
        do_txn(v, 1'b1);

        // Reset in BUSY: the round-robin instance would give this tie to port 1.
        p0_valid = 1'b1; p0_addr = 32'hA0; p0_lock = 1'b0;
        p1_valid = 1'b1; p1_addr = 32'hB0; p1_lock = 1'b0;
        @(posedge clk); #1;
        chk1("pre_rst_busy", r_busy, 1'b1);
        chk1("pre_rst_gnt_rr", r_gnt, 1'b1);
        reset = 1'b0;
        mem_ready = 1'b1;
        mem_dtr = 32'h0BAD0BAD;
        #1;
        chk1("rst_busy_mem_valid_rr", r_mem_valid, 1'b0);
        chk1("rst_busy_mem_valid_fp", f_mem_valid, 1'b0);
        chk1("rst_busy_busy", r_busy, 1'b0);
        chk("rst_busy_ready", {30'b0, r_p1_ready, r_p0_ready, f_p1_ready, f_p0_ready}, 32'd0);
        chk1("rst_busy_gnt", r_gnt, 1'b0);
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {30'b0, r_p1_ready, r_p0_ready, f_p1_ready, f_p0_ready}, 32'd0);
        chk1("post_rst_busy", r_busy, 1'b0);
        chk("post_rst_mem_addr", r_mem_addr, 32'h0);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        v = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hC0, 32'hD0, 32'h600DCAFE, 1, 1'b0, 1'b0};
        do_txn(v, 1'b0);

        // Randomized run against the reference model, from a fresh reset.
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            m_last[k] = 1'b1;
            m_lock[k] = 1'b0;
            m_lport[k] = 1'b0;
        end
        for (int n = 0; n < 200; n++) begin
            int req;
            req = int'($urandom_range(0, 3));
            if (req == 0) begin
                mem_ready = 1'($urandom_range(0, 1));
                mem_dtr = $urandom;
                @(negedge clk);
                chk("rand_idle_ready", {30'b0, r_p1_ready, r_p0_ready, f_p1_ready, f_p0_ready}, 32'd0);
                chk1("rand_idle_mem_valid", r_mem_valid, 1'b0);
                @(posedge clk); #1;
                mem_ready = 1'b0;
            end else begin
                v.v0 = (req != 2);
                v.v1 = (req != 1);
                v.rw0 = 1'($urandom_range(0, 1));
                v.rw1 = 1'($urandom_range(0, 1));
                v.l0 = ($urandom_range(0, 3) == 0);
                v.l1 = ($urandom_range(0, 3) == 0);
                v.a0 = $urandom;
                v.a1 = $urandom;
                v.d = $urandom;
                v.lat = int'($urandom_range(1, 4));
                v.err = model_pick(0, v.v0, v.v1);
                v.efp = model_pick(1, v.v0, v.v1);
                do_txn(v, $urandom_range(0, 3) == 0);
                m_last[0] = v.err;
                m_lport[0] = v.err;
                m_lock[0] = v.err ? v.l1 : v.l0;
                m_last[1] = v.efp;
                m_lport[1] = v.efp;
                m_lock[1] = v.efp ? v.l1 : v.l0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter RR, default 1: 1 selects round-robin arbitration; 0 selects fixed priority with port 0 highest.
REQ-002 Parameter AW, default 32: address and data width of all ports.
REQ-003 clk  input  1  single clock; all logic is rising-edge except the asynchronous reset.
REQ-004 reset  input  1  reset, asynchronous and active-low; asserting it immediately forces the reset state.
REQ-005 p0_valid / p1_valid  input  1  request from port 0 (instruction fetch) / port 1 (data); held high until that port's ready.
REQ-006 p0_rw / p1_rw  input  1  per-port direction; write = 1.
REQ-007 p0_addr / p1_addr  input  AW  per-port byte address.
REQ-008 p0_dtw / p1_dtw  input  AW  per-port write data.
REQ-009 p0_lock / p1_lock  input  1  per-port lock; keeps the grant for the next transaction of the same port (read-modify-write).
REQ-010 p0_ready / p1_ready  output  1  one-cycle completion pulse to the granted port.
REQ-011 p0_dtr / p1_dtr  output  AW  read data to port 0 / port 1; valid in the ready cycle.
REQ-012 mem_valid  output  1  request to the SRAM frontend.
REQ-013 mem_rw  output  1  direction to the SRAM frontend.
REQ-014 mem_addr  output  AW  address to the SRAM frontend.
REQ-015 mem_dtw  output  AW  write data to the SRAM frontend.
REQ-016 mem_ready  input  1  one-cycle completion pulse from the SRAM frontend.
REQ-017 mem_dtr  input  AW  read data from the SRAM frontend.
REQ-018 gnt  output  1  currently or last granted port, 0 or 1.
REQ-019 busy  output  1  high while in BUSY.

Function
REQ-020 The FSM shall have two states: IDLE and BUSY.
REQ-021 IDLE, no valid: remain in IDLE; mem_valid = 0.
REQ-022 IDLE, one or both valid: register the winner's rw/addr/dtw into mem_rw/mem_addr/mem_dtw, set gnt, go to BUSY; mem_valid rises 1 cycle after the requester's valid.
REQ-023 RR=1 with both ports valid: grant the port not granted last; after reset, port 0 wins the first tie.
REQ-024 RR=0 with both ports valid: port 0 always wins.
REQ-025 Lock override: if the last completed transaction had its lock high and that port is valid in IDLE, grant it regardless of RR; lock is sampled at completion.
REQ-026 BUSY: mem_valid = !mem_ready, combinational, so the frontend never samples a stale valid in its ready cycle.
REQ-027 BUSY: mem_rw, mem_addr and mem_dtw shall stay stable and ignore upstream changes.
REQ-028 BUSY with mem_ready: pulse pN_ready for gnt's port combinationally in the same cycle, then go to IDLE.
REQ-029 pN_dtr shall equal mem_dtr for both ports; it is qualified only by pN_ready.
REQ-030 The other port's ready shall stay 0 throughout.
REQ-031 A requester dropping valid in BUSY shall not abort the transaction; it completes and its ready pulse is ignored.
REQ-032 Minimum spacing between grants: one IDLE cycle after each completion.
REQ-033 No port shall wait more than one transaction of the other port unless that port holds lock (RR=1).
REQ-034 mem_ready seen in IDLE shall be ignored and raise no ready.

Reset
REQ-035 Reset shall set: state IDLE; gnt 0; last-grant pointer so port 0 wins the next tie; lock memory 0; mem_rw, mem_addr, mem_dtw 0.
REQ-036 Reset shall set all ready outputs, mem_valid and busy to 0 while asserted.
REQ-037 Reset mid-BUSY shall abandon the transaction with no ready pulse; resetting the SRAM frontend is the integrator's responsibility.

Structure
REQ-038 The shared package shall hold the state encoding (IDLE = 0, BUSY = 1) and the port-index constants.
REQ-039 A single sub-module, sram_arb_pick, shall be the combinational winner select (valids, last grant, lock, RR -> winner).

Verification
REQ-040 Single port: p0 read 0x0000_1000; mem_ready at cycle 5 with mem_dtr 0xDEADBEEF -> mem_valid rises cycle 1, p0_ready cycle 5, p0_dtr 0xDEADBEEF, p1_ready 0.
REQ-041 Tie, RR=1: both valid for 4 transactions -> grant order 0,1,0,1.
REQ-042 Tie, RR=0: both valid -> grant order 0,0,0,0.
REQ-043 Lock: p1 write 0x20 with lock=1, then p1 write 0x20 while p0 is also valid -> p1 is granted twice before p0.
REQ-044 Stability and ready cycle: in BUSY change p0_addr to 0xFFFF_FFFF -> mem_addr holds the granted value; in the mem_ready cycle mem_valid = 0.
REQ-045 Mid-BUSY reset: assert reset in BUSY -> mem_valid 0 immediately; after release, no ready pulse, state IDLE, and next tie goes to port 0.
